// File: rtl/serializer_arb.sv
// Round-robin arbiter feeding a single serializer.
// One word in flight at a time: IDLE grants, LOAD strobes, WAIT tracks busy.
module serializer_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_ser_wen,
  output logic [DATA_WIDTH-1:0]         o_ser_data,
  input  logic                          i_ser_busy,
  output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
  output logic                          o_active,
  output logic                          o_err
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0]         last_grant;
  logic [IW-1:0]         grant_id;
  logic [IW-1:0]         winner;
  logic                  found;
  logic                  first_wait;
  logic                  err;
  logic                  take;
  logic                  err_set;
  logic                  wen;
  logic [NUM_REQ-1:0]    ready;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] word;
  int                    base;

  // Search starts just past the last transferred requester and wraps.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    base   = int'({{(32-IW){1'b0}}, last_grant});
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && i_req_valid[(base + k) % NUM_REQ]) begin
        found  = 1'b1;
        winner = IW'((base + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    word = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (winner == IW'(n)) begin
        word = i_req_data[n*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_nx = state;
    ready    = '0;
    wen      = 1'b0;
    take     = 1'b0;
    err_set  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!i_ser_busy && found) begin
          ready    = NUM_REQ'(1) << winner;
          take     = 1'b1;
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        wen      = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (!i_ser_busy) begin
          err_set  = first_wait;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      grant_id   <= '0;
      err        <= 1'b0;
      first_wait <= 1'b0;
    end else begin
      state      <= state_nx;
      first_wait <= (state == S_LOAD);
      if (take) begin
        last_grant <= winner;
        grant_id   <= winner;
      end
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (take) begin
      hold <= word;
    end
  end

  // Reset kills any handshake or strobe in the same cycle.
  assign o_req_ready = i_rst ? '0 : ready;
  assign o_ser_wen   = wen & ~i_rst;
  assign o_ser_data  = hold;
  assign o_grant_id  = grant_id;
  assign o_active    = (state != S_IDLE);
  assign o_err       = err;

endmodule

// File: tb/tb_serializer_arb.sv
// Bench for serializer_arb: transaction model with per-cycle compare,
// a DATA_WIDTH-cycle serializer model, and literal scenario checks.
module tb_serializer_arb;

  localparam int DW = 8;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            ser_wen;
  logic [DW-1:0]   ser_data;
  logic            ser_busy;
  logic [1:0]      grant_id;
  logic            active;
  logic            err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int bmode = 0;
  int scnt = 0;

  serializer_arb #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_valid(req_valid),
    .i_req_data (req_data),
    .o_req_ready(req_ready),
    .o_ser_wen  (ser_wen),
    .o_ser_data (ser_data),
    .i_ser_busy (ser_busy),
    .o_grant_id (grant_id),
    .o_active   (active),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Serializer: busy for DW cycles after each load strobe.
  always @(posedge clk) begin
    if (rst) scnt <= 0;
    else if (ser_wen) scnt <= DW;
    else if (scnt != 0) scnt <= scnt - 1;
  end

  assign ser_busy = (bmode == 1) ? 1'b1 :
                    (bmode == 2) ? 1'b0 : (scnt != 0);

  task automatic check(string name, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, got, exp, cyc);
    end
  endtask

  // Model: one transaction in flight, tracked by its age in cycles
  // since the grant (1 = strobe cycle, 2 = first wait cycle).
  bit            m_fly;
  int            m_age;
  int            m_last;
  int            m_gid;
  bit            m_err;
  logic [DW-1:0] m_data;
  int            pk;
  logic [NR-1:0] e_ready;
  bit            e_wen;

  int            g_cyc[$];
  int            w_cyc[$];
  int            w_gid[$];
  int            w_dat[$];

  always @(negedge clk) begin
    if (rst) begin
      check("rst_ready", 32'(req_ready), 0);
      check("rst_wen", 32'(ser_wen), 0);
      m_fly  = 0;
      m_age  = 0;
      m_last = NR - 1;
      m_gid  = 0;
      m_err  = 0;
    end else begin
      e_ready = '0;
      pk = -1;
      if (!m_fly && !ser_busy) begin
        for (int k = 1; k <= NR; k++) begin
          if (pk < 0 && req_valid[(m_last + k) % NR])
            pk = (m_last + k) % NR;
        end
        if (pk >= 0) e_ready[pk] = 1'b1;
      end
      e_wen = m_fly && (m_age == 1);
      check("ready", 32'(req_ready), 32'(e_ready));
      check("ready_onehot0", 32'($onehot0(req_ready)), 1);
      check("wen", 32'(ser_wen), 32'(e_wen));
      check("active", 32'(active), 32'(m_fly));
      check("grant_id", 32'(grant_id), 32'(m_gid));
      check("err", 32'(err), 32'(m_err));
      if (e_wen) check("ser_data", 32'(ser_data), 32'(m_data));
      if (req_ready != 0) g_cyc.push_back(cyc);
      if (ser_wen) begin
        w_cyc.push_back(cyc);
        w_gid.push_back(int'(grant_id));
        w_dat.push_back(int'(ser_data));
      end
      if (pk >= 0) begin
        m_fly  = 1;
        m_age  = 1;
        m_last = pk;
        m_gid  = pk;
        m_data = req_data[pk*DW +: DW];
      end else if (m_fly) begin
        if (m_age >= 2 && !ser_busy) begin
          if (m_age == 2) m_err = 1;
          m_fly = 0;
        end
        if (m_age < 1000) m_age++;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    g_cyc.delete();
    w_cyc.delete();
    w_gid.delete();
    w_dat.delete();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    for (int n = 0; n < NR; n++) req_data[n*DW +: DW] = 8'(8'h10 + n);
    do_reset();
    @(negedge clk);
    check("reset_gid", 32'(grant_id), 0);
    check("reset_active", 32'(active), 0);
    check("reset_err", 32'(err), 0);
    @(posedge clk);
    #1;

    // Single word from requester 0.
    clear_log();
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    run(1);
    req_valid = '0;
    run(14);
    check("s1_count", 32'(w_cyc.size()), 1);
    if (w_cyc.size() >= 1) begin
      check("s1_data", 32'(w_dat[0]), 32'h A5);
      check("s1_gid", 32'(w_gid[0]), 0);
      check("s1_latency", 32'(w_cyc[0] - g_cyc[0]), 1);
    end

    // All valid: order 0,1,2,3 at 11-cycle spacing.
    do_reset();
    clear_log();
    req_data[7:0] = 8'h10;
    req_valid = 4'b1111;
    run(34);
    req_valid = '0;
    run(14);
    check("s2_count", 32'(w_cyc.size()), 4);
    if (w_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("s2_gid", 32'(w_gid[i]), 32'(i));
        check("s2_data", 32'(w_dat[i]), 32'(8'h10 + i));
        if (i > 0)
          check("s2_spacing", 32'(w_cyc[i] - w_cyc[i-1]), 11);
      end
    end

    // Wrap: last grant 2, then 0 and 2 valid.
    do_reset();
    req_valid = 4'b0100;
    run(1);
    req_valid = '0;
    run(14);
    clear_log();
    req_valid = 4'b0101;
    run(12);
    req_valid = '0;
    run(14);
    check("s3_count", 32'(w_gid.size()), 2);
    if (w_gid.size() == 2) begin
      check("s3_first", 32'(w_gid[0]), 0);
      check("s3_second", 32'(w_gid[1]), 2);
    end

    // Busy held in IDLE blocks the grant.
    clear_log();
    bmode = 1;
    req_valid = 4'b0010;
    run(4);
    @(negedge clk);
    check("s4_ready_blocked", 32'(req_ready), 0);
    @(posedge clk);
    #1 bmode = 0;
    run(1);
    req_valid = '0;
    run(14);
    check("s4_count", 32'(w_gid.size()), 1);
    if (w_gid.size() == 1) check("s4_gid", 32'(w_gid[0]), 1);

    // Serializer never busy: sticky error.
    bmode = 2;
    req_valid = 4'b1000;
    run(1);
    req_valid = '0;
    run(6);
    check("s5_err_set", 32'(err), 1);
    run(5);
    check("s5_err_sticky", 32'(err), 1);
    bmode = 0;
    do_reset();
    @(negedge clk);
    check("s5_err_cleared", 32'(err), 0);
    @(posedge clk);
    #1;

    // Reset mid-WAIT; requester 0 regains priority.
    req_valid = 4'b0100;
    run(1);
    req_valid = '0;
    run(4);
    check("s6_in_wait", 32'(active), 1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    @(negedge clk);
    check("s6_active", 32'(active), 0);
    check("s6_err", 32'(err), 0);
    @(posedge clk);
    #1 req_valid = 4'b1001;
    @(negedge clk);
    check("s6_prio", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = '0;
    run(14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serializer_arb.md
SERIALIZER_ARB -- requirements
Module: serializer_arb

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: width of one serializer word.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, legal range 2..16: number of requesters.
REQ-003 The block SHALL have i_clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 The block SHALL have i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have i_req_valid, input, NUM_REQ bits: bit n set means requester n offers a word.
REQ-006 The block SHALL have i_req_data, input, NUM_REQ*DATA_WIDTH bits: requester n word in bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-007 The block SHALL have o_req_ready, output, NUM_REQ bits: one-hot or zero; a transfer occurs on an edge where valid[n] and ready[n] are both 1.
REQ-008 The block SHALL have o_ser_wen, output, 1 bit: load strobe to the serializer.
REQ-009 The block SHALL have o_ser_data, output, DATA_WIDTH bits: word presented to the serializer.
REQ-010 The block SHALL have i_ser_busy, input, 1 bit: serializer busy flag.
REQ-011 The block SHALL have o_grant_id, output, $clog2(NUM_REQ) bits: index of the requester whose word is in flight.
REQ-012 The block SHALL have o_active, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have o_err, output, 1 bit: sticky handshake error flag.

Function
REQ-014 The block SHALL implement the FSM states IDLE, LOAD and WAIT.
REQ-015 In IDLE with i_ser_busy=0 and any i_req_valid set, the block SHALL pick the winner round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap.
REQ-016 In that IDLE cycle, o_req_ready SHALL assert combinationally for the winner only; o_req_ready SHALL be 0 in every other state and cycle.
REQ-017 On the transfer edge, the block SHALL capture the winner's word into a holding register, set last_grant and o_grant_id to the winner, and go to LOAD.
REQ-018 In IDLE with i_ser_busy=1, the block SHALL grant nothing.
REQ-019 In LOAD, o_ser_wen SHALL be 1 for exactly one cycle with o_ser_data equal to the holding register; next state WAIT.
REQ-020 In WAIT, i_ser_busy=1 SHALL keep the state; on the first cycle with i_ser_busy=0, the next state SHALL be IDLE.
REQ-021 If i_ser_busy=0 in the first WAIT cycle (serializer did not accept), the block SHALL set o_err=1 and go to IDLE.
REQ-022 o_err SHALL stay set until reset.
REQ-023 Latency from transfer edge to o_ser_wen SHALL be 1 cycle.
REQ-024 Minimum spacing between grants SHALL be DATA_WIDTH+3 cycles for a DATA_WIDTH-cycle serializer.
REQ-025 A requester dropping valid before it is granted SHALL lose no state; the pointer SHALL advance only on a transfer.
REQ-026 A single active requester SHALL be granted back-to-back; with all requesters valid, the grant order SHALL be 0,1,...,NUM_REQ-1,0,...
REQ-027 o_ser_data SHALL hold its value outside LOAD; its contents are don't-care when o_ser_wen=0.

Reset
REQ-028 On reset, the block SHALL enter state IDLE and set last_grant to NUM_REQ-1, so requester 0 has first priority.
REQ-029 On reset, o_grant_id SHALL be 0, o_err 0, o_ser_wen 0, o_req_ready 0 and o_active 0.
REQ-030 Reset in LOAD or WAIT SHALL abort the cycle and discard the held word, with no o_ser_wen pulse on the reset edge; the serializer is reset by the same i_rst.
REQ-031 The holding register SHALL need no reset.

Verification
REQ-032 Scenario: reset, then valid=4'b0001, data0=8'hA5 -> ready[0] one cycle; o_ser_wen next cycle with o_ser_data=8'hA5; grant_id=0; o_active high until busy falls.
REQ-033 Scenario: valid=4'b1111 held for 4 words -> grant order 0,1,2,3; each o_ser_wen spaced 11 cycles apart (DATA_WIDTH=8); ready never has more than one bit set.
REQ-034 Scenario: last_grant=2, valid=4'b0101 -> requester 0 wins (wrap); next grant 2.
REQ-035 Scenario: i_ser_busy forced 1 in IDLE with valid=4'b0010 -> ready stays 4'b0000 until busy=0.
REQ-036 Scenario: i_ser_busy tied 0 and a word is granted -> o_err=1 in the cycle after WAIT entry; stays 1 until i_rst.
REQ-037 Scenario: i_rst in WAIT mid-frame -> next cycle state IDLE, o_active=0, o_err=0, requester 0 highest priority.
